axo_mem_ram: RTL

Single-port, word-organised RAM that acts as the responder end of an `axo_mem_bus`, sitting on one `mems[]` port of `axo_mem_xbar`. It accepts byte, halfword and word reads and writes with a configurable number of wait states. It returns lane-aligned read data and flags malformed accesses with `error`.

---
 rtl/axo_mem_ram.sv | 139 +++++++++++++
 1 files changed

// File: rtl/axo_mem_ram.sv
// axo_mem_ram: single-port word-organised RAM responder for an axo_mem_bus port.
// Accepts byte/half/word(/dword) accesses, inserts a fixed number of wait
// states, and returns registered, lane-aligned read data with an error flag.
module axo_mem_ram #(
  parameter int unsigned dlen    = 32,
  parameter int unsigned alen    = 32,
  parameter int unsigned depth   = 256,
  parameter int unsigned latency = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bus_re,
  input  logic            bus_we,
  input  logic [1:0]      bus_asize,
  input  logic [alen-1:0] bus_addr,
  input  logic [dlen-1:0] bus_wdata,
  output logic [dlen-1:0] bus_rdata,
  output logic            bus_ready,
  output logic            bus_error
);

  localparam int unsigned nb = dlen / 8;
  localparam int unsigned lb = $clog2(nb);
  localparam int unsigned aw = $clog2(depth);
  localparam int unsigned ab = lb + aw;
  // WAIT is entered with latency-1 so that exactly `latency` WAIT cycles elapse.
  localparam logic [3:0] lat_init = (latency > 0) ? 4'(latency - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  logic [dlen-1:0] mem [depth];

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic            fault_q;
  logic [dlen-1:0] rdata_q;
  logic            ready_q;
  logic            error_q;

  logic [aw-1:0]   idx;
  logic [lb-1:0]   off;
  logic [3:0]      size_bytes;
  logic [3:0]      align_mask;
  logic            misalign;
  logic            fault;
  logic            req;
  logic            accept;
  logic [nb-1:0]   be;
  logic [dlen-1:0] lane_mask;

  // Decode the presented request: word index, lane enables and fault checks.
  always_comb begin
    idx        = bus_addr[ab-1:lb];
    off        = bus_addr[lb-1:0];
    size_bytes = 4'd1 << bus_asize;
    align_mask = size_bytes - 4'd1;
    misalign   = |(off & align_mask[lb-1:0]);
    fault      = (bus_re & bus_we) | (32'(bus_asize) > lb) | misalign;
    req        = bus_re | bus_we;
    accept     = (state_q == StIdle) & req;
    be         = '0;
    lane_mask  = '0;
    for (int i = 0; i < int'(nb); i++) begin
      be[i] = (i >= int'(off)) && (i < int'(off) + int'(size_bytes));
      lane_mask[i*8 +: 8] = {8{be[i]}};
    end
  end

  // Commit enabled write lanes on the acceptance edge; the array is never reset.
  always_ff @(posedge clk) begin
    if (accept && bus_we && !fault && !rst) begin
      for (int i = 0; i < int'(nb); i++) begin
        if (be[i]) begin
          mem[idx][i*8 +: 8] <= bus_wdata[i*8 +: 8];
        end
      end
    end
  end

  // Access sequencer: accept, count wait states, then strobe one response cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      fault_q <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          ready_q <= 1'b0;
          error_q <= 1'b0;
          if (req) begin
            fault_q <= fault;
            // Only the addressed lanes of a clean read carry data.
            if (fault || bus_we) begin
              rdata_q <= '0;
            end else begin
              rdata_q <= mem[idx] & lane_mask;
            end
            if (latency > 0) begin
              state_q <= StWait;
              cnt_q   <= lat_init;
            end else begin
              state_q <= StResp;
              ready_q <= 1'b1;
              error_q <= fault;
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q <= StResp;
            ready_q <= 1'b1;
            error_q <= fault_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          state_q <= StIdle;
          ready_q <= 1'b0;
          error_q <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b0;
          error_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus_rdata = rdata_q;
  assign bus_ready = ready_q;
  assign bus_error = error_q;

endmodule
